// File: rtl/ltc2308_responder.sv
// Device-side model of the LTC2308 12-bit, 8-channel SPI ADC. It answers the
// CONVST/SCK/SDI signals from our ADC master and returns the selected channel's code on SDO.
module ltc2308_responder #(
    parameter int DATA_W      = 12,
    parameter int CONV_CYCLES = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [8*DATA_W-1:0]   chan_data,
    input  logic                  ADC_CONVST,
    input  logic                  ADC_SCK,
    input  logic                  ADC_SDI,
    output logic                  ADC_SDO,
    output logic                  busy,
    output logic [5:0]            cfg_word,
    output logic                  cfg_valid,
    output logic                  proto_err
);

    localparam int          CNT_W     = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam logic [5:0]  CFG_RESET = 6'b100010;
    localparam logic [DATA_W-1:0] MSB_MASK = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_SHIFT   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       conv_cnt_q, conv_cnt_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [5:0]             cfg_shift_q, cfg_shift_d;
    logic [5:0]             cfg_word_q, cfg_word_d;
    logic                   cfg_valid_q, cfg_valid_d;
    logic [DATA_W-1:0]      sample_q, sample_d;
    logic                   sdo_q, sdo_d;
    logic                   busy_q, busy_d;
    logic                   proto_err_q, proto_err_d;

    logic [SYNC_STAGES-1:0] convst_sync_q;
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] sdi_sync_q;
    logic                   convst_prev_q;
    logic                   sck_prev_q;

    logic                   convst_cur_s, sck_cur_s, sdi_cur_s;
    logic                   convst_rise_s, sck_rise_s, sck_fall_s;
    logic [3:0]             sdo_idx_s;
    logic [DATA_W-1:0]      new_sample_s;

    // Channel ch = {S1, S0, O/S}; bipolar flips the MSB (offset binary to two's complement).
    function automatic logic [DATA_W-1:0] pick_sample(
        input logic [2:0]          ch,
        input logic                uni,
        input logic [8*DATA_W-1:0] data
    );
        logic [DATA_W-1:0] raw;
        raw = data[ch*DATA_W +: DATA_W];
        if (uni) begin
            return raw;
        end else begin
            return raw ^ MSB_MASK;
        end
    endfunction

    assign convst_cur_s  = convst_sync_q[SYNC_STAGES-1];
    assign sck_cur_s     = sck_sync_q[SYNC_STAGES-1];
    assign sdi_cur_s     = sdi_sync_q[SYNC_STAGES-1];
    assign convst_rise_s = convst_cur_s & ~convst_prev_q;
    assign sck_rise_s    = sck_cur_s & ~sck_prev_q;
    assign sck_fall_s    = ~sck_cur_s & sck_prev_q;
    assign sdo_idx_s     = 4'(DATA_W - 1) - bit_cnt_q;
    assign new_sample_s  = pick_sample({cfg_word_q[3], cfg_word_q[2], cfg_word_q[4]},
                                       cfg_word_q[1], chan_data);

    // Input synchronisers and previous-value registers for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            convst_sync_q <= '0;
            sck_sync_q    <= '0;
            sdi_sync_q    <= '0;
            convst_prev_q <= 1'b0;
            sck_prev_q    <= 1'b0;
        end else begin
            convst_sync_q <= {convst_sync_q[SYNC_STAGES-2:0], ADC_CONVST};
            sck_sync_q    <= {sck_sync_q[SYNC_STAGES-2:0], ADC_SCK};
            sdi_sync_q    <= {sdi_sync_q[SYNC_STAGES-2:0], ADC_SDI};
            convst_prev_q <= convst_cur_s;
            sck_prev_q    <= sck_cur_s;
        end
    end

    // Protocol state, counters and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            conv_cnt_q  <= '0;
            bit_cnt_q   <= 4'd0;
            cfg_shift_q <= 6'd0;
            cfg_word_q  <= CFG_RESET;
            cfg_valid_q <= 1'b0;
            sample_q    <= '0;
            sdo_q       <= 1'b0;
            busy_q      <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            conv_cnt_q  <= conv_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            cfg_shift_q <= cfg_shift_d;
            cfg_word_q  <= cfg_word_d;
            cfg_valid_q <= cfg_valid_d;
            sample_q    <= sample_d;
            sdo_q       <= sdo_d;
            busy_q      <= busy_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        conv_cnt_d  = conv_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        cfg_shift_d = cfg_shift_q;
        cfg_word_d  = cfg_word_q;
        cfg_valid_d = 1'b0;
        sample_d    = sample_q;
        sdo_d       = sdo_q;
        busy_d      = busy_q;
        proto_err_d = proto_err_q;

        case (state_q)
            ST_IDLE: begin
                sdo_d  = 1'b0;
                busy_d = 1'b0;
                if (convst_rise_s) begin
                    state_d    = ST_CONVERT;
                    sample_d   = new_sample_s;
                    conv_cnt_d = CNT_W'(CONV_CYCLES - 1);
                    busy_d     = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_CONVERT: begin
                if (sck_rise_s || sck_fall_s) begin
                    proto_err_d = 1'b1;
                end else begin
                    proto_err_d = proto_err_q;
                end
                if (conv_cnt_q == '0) begin
                    state_d     = ST_SHIFT;
                    busy_d      = 1'b0;
                    sdo_d       = sample_q[DATA_W-1];
                    bit_cnt_d   = 4'd0;
                    cfg_shift_d = 6'd0;
                end else begin
                    conv_cnt_d = conv_cnt_q - CNT_W'(1);
                end
            end

            ST_SHIFT: begin
                // A new CONVST aborts the transfer and outranks any SCK edge in the same clock.
                if (convst_rise_s) begin
                    proto_err_d = 1'b1;
                    state_d     = ST_CONVERT;
                    sample_d    = new_sample_s;
                    conv_cnt_d  = CNT_W'(CONV_CYCLES - 1);
                    busy_d      = 1'b1;
                    sdo_d       = 1'b0;
                end else if (sck_rise_s) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q < 4'd6) begin
                        cfg_shift_d = {cfg_shift_q[4:0], sdi_cur_s};
                    end else begin
                        cfg_shift_d = cfg_shift_q;
                    end
                    if (bit_cnt_q == 4'(DATA_W - 1)) begin
                        cfg_word_d  = cfg_shift_q;
                        cfg_valid_d = 1'b1;
                        state_d     = ST_IDLE;
                        sdo_d       = 1'b0;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else if (sck_fall_s) begin
                    if (bit_cnt_q < 4'(DATA_W)) begin
                        sdo_d = sample_q[sdo_idx_s];
                    end else begin
                        sdo_d = 1'b0;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end

            default: begin
                state_d = ST_IDLE;
                sdo_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign ADC_SDO   = sdo_q;
    assign busy      = busy_q;
    assign cfg_word  = cfg_word_q;
    assign cfg_valid = cfg_valid_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_ltc2308_responder.sv
// Self-checking bench for ltc2308_responder: directed vector table, randomized
// transfers against a behavioural model, and hand-written protocol corner cases.
`timescale 1ns/1ps
module tb_ltc2308_responder;

    localparam int CONV_CYCLES = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [95:0] chan_data = 96'h0F1_E2D_C3B_B49_A57_965_873_781;
    logic        convst = 1'b0;
    logic        sck = 1'b0;
    logic        sdi = 1'b0;
    logic        sdo, busy, cfg_valid, proto_err;
    logic [5:0]  cfg_word;

    int n_vec = 0;
    int n_err = 0;
    int busy_cnt = 0;
    int valid_cnt = 0;

    logic [5:0] m_cfg = 6'b100010;
    logic       m_perr = 1'b0;

    typedef struct {
        int         ch;
        logic [11:0] code;
        logic [5:0]  send_cfg;
        logic [11:0] exp_data;
    } vec_t;

    vec_t vecs [7];

    ltc2308_responder #(.DATA_W(12), .CONV_CYCLES(CONV_CYCLES), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .chan_data  (chan_data),
        .ADC_CONVST (convst),
        .ADC_SCK    (sck),
        .ADC_SDI    (sdi),
        .ADC_SDO    (sdo),
        .busy       (busy),
        .cfg_word   (cfg_word),
        .cfg_valid  (cfg_valid),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (cfg_valid) valid_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected SDO word from the datasheet rules, using plain arithmetic.
    function automatic logic [11:0] model_sample(input logic [5:0] cfg, input logic [95:0] cd);
        int ch;
        int v;
        ch = (cfg[3] ? 4 : 0) + (cfg[2] ? 2 : 0) + (cfg[4] ? 1 : 0);
        v = int'((cd >> (ch * 12)) & 96'hFFF);
        if (!cfg[1]) v = (v + 2048) % 4096;
        return 12'(v);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_chan(input int ch, input logic [11:0] code);
        chan_data[ch*12 +: 12] = code;
    endtask

    // Pulse CONVST, optionally toggle SCK during conversion, then wait out busy.
    task automatic convert(input int sck_pulses);
        int b0;
        int t;
        b0 = busy_cnt;
        convst = 1'b1;
        tick(3);
        convst = 1'b0;
        t = 0;
        while (!busy && t < 20) begin tick(1); t++; end
        check("busy_rise", 32'(busy), 32'd1);
        for (int p = 0; p < sck_pulses; p++) begin
            sck = 1'b1; tick(3); sck = 1'b0; tick(3);
        end
        t = 0;
        while (busy && t < 300) begin tick(1); t++; end
        check("busy_fall", 32'(busy), 32'd0);
        check("busy_width", 32'(busy_cnt - b0), 32'(CONV_CYCLES));
        tick(2);
    endtask

    task automatic sck_bit(input logic bit_in, output logic sdo_seen);
        sdi = bit_in;
        tick(2);
        sdo_seen = sdo;
        sck = 1'b1;
        tick(4);
        sck = 1'b0;
        tick(4);
    endtask

    task automatic transfer(input logic [5:0] cfg, output logic [11:0] data);
        logic b;
        for (int i = 0; i < 12; i++) begin
            sck_bit((i < 6) ? cfg[5-i] : 1'($urandom), b);
            data[11-i] = b;
        end
        tick(2);
    endtask

    // One full conversion plus 12-bit transfer with result and config checks.
    task automatic full_txn(input string tag, input logic [11:0] exp, input logic [5:0] send_cfg);
        logic [11:0] got;
        int v0;
        convert(0);
        v0 = valid_cnt;
        transfer(send_cfg, got);
        check({tag, "_sdo_word"}, 32'(got), 32'(exp));
        check({tag, "_cfg_word"}, 32'(cfg_word), 32'(send_cfg));
        check({tag, "_cfg_valid_len"}, 32'(valid_cnt - v0), 32'd1);
        check({tag, "_sdo_idle"}, 32'(sdo), 32'd0);
        check({tag, "_proto_err"}, 32'(proto_err), 32'(m_perr));
        m_cfg = send_cfg;
    endtask

    initial begin
        logic [11:0] got;
        logic        b;
        int          v0;

        vecs[0] = '{0, 12'hABC, 6'b110010, 12'hABC};
        vecs[1] = '{1, 12'h123, 6'b101110, 12'h123};
        vecs[2] = '{6, 12'h5A5, 6'b110000, 12'h5A5};
        vecs[3] = '{1, 12'h000, 6'b110000, 12'h800};
        vecs[4] = '{1, 12'hFFF, 6'b010011, 12'h7FF};
        vecs[5] = '{1, 12'h6E1, 6'b100010, 12'h6E1};
        vecs[6] = '{0, 12'h3C7, 6'b100010, 12'h3C7};

        tick(3);
        reset_n = 1'b1;
        tick(3);
        check("rst_sdo", 32'(sdo), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cfg_word", 32'(cfg_word), 32'h22);
        check("rst_cfg_valid", 32'(cfg_valid), 32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);

        for (int i = 0; i < 7; i++) begin
            set_chan(vecs[i].ch, vecs[i].code);
            full_txn($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].send_cfg);
        end

        for (int i = 0; i < 20; i++) begin
            chan_data = {$urandom, $urandom, $urandom};
            full_txn($sformatf("rnd%0d", i), model_sample(m_cfg, chan_data), 6'($urandom));
        end

        // Abort after 5 config bits: old config stays and drives the next result.
        m_cfg = cfg_word;
        chan_data = {$urandom, $urandom, $urandom};
        convert(0);
        v0 = valid_cnt;
        for (int i = 0; i < 5; i++) sck_bit(1'(~m_cfg[5-i]), b);
        convert(0);
        m_perr = 1'b1;
        check("abort_cfg_word", 32'(cfg_word), 32'(m_cfg));
        check("abort_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("abort_proto_err", 32'(proto_err), 32'd1);
        transfer(6'b100010, got);
        check("abort_sdo_word", 32'(got), 32'(model_sample(m_cfg, chan_data)));
        m_cfg = 6'b100010;

        // Asynchronous reset during bit 7 of a transfer.
        set_chan(6, 12'h9D3);
        set_chan(0, 12'h4B6);
        full_txn("pre_rst", model_sample(m_cfg, chan_data), 6'b101110);
        convert(0);
        for (int i = 0; i < 6; i++) sck_bit(1'b1, b);
        sck = 1'b1;
        tick(1);
        reset_n = 1'b0;
        #1;
        check("midrst_sdo", 32'(sdo), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_cfg_word", 32'(cfg_word), 32'h22);
        check("midrst_proto_err", 32'(proto_err), 32'd0);
        check("midrst_cfg_valid", 32'(cfg_valid), 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick(2);
        sck = 1'b0;
        tick(4);
        m_cfg = 6'b100010;
        m_perr = 1'b0;
        full_txn("post_rst", 12'h4B6, 6'b110010);

        // SCK toggling during conversion flags an error but leaves the result intact.
        set_chan(1, 12'h2E7);
        convert(3);
        m_perr = 1'b1;
        check("convsck_proto_err", 32'(proto_err), 32'd1);
        v0 = valid_cnt;
        transfer(6'b100010, got);
        check("convsck_sdo_word", 32'(got), 32'h2E7);
        check("convsck_cfg_valid_len", 32'(valid_cnt - v0), 32'd1);
        m_cfg = 6'b100010;
        full_txn("final", model_sample(m_cfg, chan_data), 6'b101110);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
